// File: rtl/arithmetic_unit_if.sv
// Operand/result bundle for the shared arithmetic unit.
// The controller drives the master side; the arithmetic unit sits on the slave side.
interface arithmetic_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_value_a;
    logic [WIDTH-1:0] i_value_b;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_value_add;
    logic [WIDTH-1:0] o_value_sub;
    logic [WIDTH-1:0] o_value_mul;
    logic [WIDTH-1:0] o_value_div;
    logic [WIDTH-1:0] o_value_rem;
    logic             o_div_by_zero;

    modport master (
        output i_start, i_value_a, i_value_b,
        input  o_busy, o_valid, o_value_add, o_value_sub, o_value_mul,
               o_value_div, o_value_rem, o_div_by_zero
    );

    modport slave (
        input  i_start, i_value_a, i_value_b,
        output o_busy, o_valid, o_value_add, o_value_sub, o_value_mul,
               o_value_div, o_value_rem, o_div_by_zero
    );
endinterface

// File: rtl/arithmetic_unit.sv
// Registered unsigned add/sub/mul plus a multi-cycle restoring divider.
// All results are published together, along with a one-cycle valid strobe.
module arithmetic_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    arithmetic_unit_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quot_q, quot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, valid_q, valid_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   add_q, add_d, sub_q, sub_d, mul_q, mul_d;
    logic [WIDTH-1:0]   div_q, div_d, rem_out_q, rem_out_d;
    logic [WIDTH:0]     shifted, trial;

    // One restoring step: shift the next dividend bit in, trial-subtract the divisor.
    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        add_d     = add_q;
        sub_d     = sub_q;
        mul_d     = mul_q;
        div_d     = div_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.i_start) begin
                    a_d     = bus.i_value_a;
                    b_d     = bus.i_value_b;
                    rem_d   = '0;
                    quot_d  = bus.i_value_a;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (cnt_q != CNT_W'(WIDTH)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!trial[WIDTH]) begin
                        rem_d  = trial[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = shifted[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Divider settled: publish every result from the latched operands.
                    add_d     = a_q + b_q;
                    sub_d     = a_q - b_q;
                    mul_d     = a_q * b_q;
                    div_d     = quot_q;
                    rem_out_d = rem_q;
                    dbz_d     = (b_q == '0);
                    busy_d    = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            add_q     <= '0;
            sub_q     <= '0;
            mul_q     <= '0;
            div_q     <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            add_q     <= add_d;
            sub_q     <= sub_d;
            mul_q     <= mul_d;
            div_q     <= div_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_value_add   = add_q;
    assign bus.o_value_sub   = sub_q;
    assign bus.o_value_mul   = mul_q;
    assign bus.o_value_div   = div_q;
    assign bus.o_value_rem   = rem_out_q;
    assign bus.o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_arithmetic_unit.sv
// Directed self-checking bench for arithmetic_unit: vector table plus
// back-to-back, ignored-start and mid-operation reset sequences.
module tb_arithmetic_unit;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arithmetic_unit_if #(.WIDTH(WIDTH)) bus ();

    arithmetic_unit #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a, b;
        logic [7:0] add, sub, mul, div, rem;
        logic       dbz;
    } vec_t;

    vec_t vecs [9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " add"}, int'(bus.o_value_add), int'(v.add));
        chk({tag, " sub"}, int'(bus.o_value_sub), int'(v.sub));
        chk({tag, " mul"}, int'(bus.o_value_mul), int'(v.mul));
        chk({tag, " div"}, int'(bus.o_value_div), int'(v.div));
        chk({tag, " rem"}, int'(bus.o_value_rem), int'(v.rem));
        chk({tag, " dbz"}, int'(bus.o_div_by_zero), int'(v.dbz));
    endtask

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        bus.i_value_a = a;
        bus.i_value_b = b;
        bus.i_start   = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start   = 1'b0;
    endtask

    // Wait (bounded) for o_valid, counting edges since the start edge; check results.
    task automatic await_check(input string tag, input vec_t v, input int already,
                               input bit check_drop);
        int cyc;
        bit seen;
        cyc  = already;
        seen = 1'b0;
        while (cyc < 30 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.o_valid) seen = 1'b1;
        end
        chk({tag, " latency"}, seen ? cyc : -1, 9);
        chk({tag, " busy in valid cycle"}, int'(bus.o_busy), 0);
        check_outputs(tag, v);
        if (check_drop) begin
            @(posedge clk);
            #1;
            chk({tag, " valid one cycle"}, int'(bus.o_valid), 0);
        end
    endtask

    initial begin
        vecs[0] = '{a: 8'd20,  b: 8'd10,  add: 8'd30,  sub: 8'd10,  mul: 8'd200, div: 8'd2,   rem: 8'd0,  dbz: 1'b0};
        vecs[1] = '{a: 8'd10,  b: 8'd20,  add: 8'd30,  sub: 8'd246, mul: 8'd200, div: 8'd0,   rem: 8'd10, dbz: 1'b0};
        vecs[2] = '{a: 8'd200, b: 8'd100, add: 8'd44,  sub: 8'd100, mul: 8'd32,  div: 8'd2,   rem: 8'd0,  dbz: 1'b0};
        vecs[3] = '{a: 8'd20,  b: 8'd20,  add: 8'd40,  sub: 8'd0,   mul: 8'd144, div: 8'd1,   rem: 8'd0,  dbz: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd7,   add: 8'd6,   sub: 8'd248, mul: 8'd249, div: 8'd36,  rem: 8'd3,  dbz: 1'b0};
        vecs[5] = '{a: 8'd37,  b: 8'd0,   add: 8'd37,  sub: 8'd37,  mul: 8'd0,   div: 8'd255, rem: 8'd37, dbz: 1'b1};
        vecs[6] = '{a: 8'd0,   b: 8'd0,   add: 8'd0,   sub: 8'd0,   mul: 8'd0,   div: 8'd255, rem: 8'd0,  dbz: 1'b1};
        vecs[7] = '{a: 8'd255, b: 8'd255, add: 8'd254, sub: 8'd0,   mul: 8'd1,   div: 8'd1,   rem: 8'd0,  dbz: 1'b0};
        vecs[8] = '{a: 8'd1,   b: 8'd255, add: 8'd0,   sub: 8'd2,   mul: 8'd255, div: 8'd0,   rem: 8'd1,  dbz: 1'b0};

        bus.i_start   = 1'b0;
        bus.i_value_a = '0;
        bus.i_value_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        chk("reset busy",  int'(bus.o_busy), 0);
        chk("reset valid", int'(bus.o_valid), 0);
        check_outputs("reset", '{a: 8'd0, b: 8'd0, add: 8'd0, sub: 8'd0, mul: 8'd0,
                                 div: 8'd0, rem: 8'd0, dbz: 1'b0});

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d busy after start", i), int'(bus.o_busy), 1);
            await_check($sformatf("vec%0d", i), vecs[i], 0, 1'b1);
        end

        // Restart while busy is ignored and live input changes do not leak in.
        @(negedge clk);
        issue(8'd20, 8'd10);
        bus.i_value_a = 8'd1;
        bus.i_value_b = 8'd1;
        bus.i_start   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.i_start   = 1'b0;
        bus.i_value_a = 8'd99;
        await_check("ignored", vecs[0], 3, 1'b1);
        begin
            bit extra;
            extra = 1'b0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (bus.o_valid) extra = 1'b1;
            end
            chk("ignored start not queued", int'(extra), 0);
        end

        // Back-to-back: start accepted in the valid cycle.
        @(negedge clk);
        issue(8'd20, 8'd10);
        await_check("b2b first", vecs[0], 0, 1'b0);
        issue(vecs[4].a, vecs[4].b);
        chk("b2b busy after second start", int'(bus.o_busy), 1);
        await_check("b2b second", vecs[4], 0, 1'b1);

        // Reset at cycle 4 of an operation aborts it and clears outputs.
        @(negedge clk);
        issue(8'd20, 8'd10);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(bus.o_busy), 0);
        chk("abort valid", int'(bus.o_valid), 0);
        check_outputs("abort", '{a: 8'd0, b: 8'd0, add: 8'd0, sub: 8'd0, mul: 8'd0,
                                 div: 8'd0, rem: 8'd0, dbz: 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit pulsed;
            pulsed = 1'b0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (bus.o_valid) pulsed = 1'b1;
            end
            chk("no valid after abort", int'(pulsed), 0);
        end
        @(negedge clk);
        issue(vecs[5].a, vecs[5].b);
        await_check("after abort", vecs[5], 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arithmetic_unit.md
# arithmetic_unit

Registered 8-bit arithmetic unit computing sum, difference, product, quotient and remainder of two unsigned operands. A start pulse latches the operands. A multi-cycle restoring divider produces the quotient. All results are published together with a one-cycle valid strobe. Sits on the datapath as a shared arithmetic resource for a controller that issues one operation set at a time.

## Interface
- WIDTH, default 8: operand and result width in bits (≥2).
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request; sampled on rising edge, honoured only when o_busy=0.
- i_value_a  input  WIDTH  unsigned operand A (dividend, minuend).
- i_value_b  input  WIDTH  unsigned operand B (divisor, subtrahend).
- o_busy  output  1  operation in progress; i_start ignored while high.
- o_valid  output  1  one-cycle strobe: all result outputs updated this cycle.
- o_value_add  output  WIDTH  (A+B) mod 2^WIDTH.
- o_value_sub  output  WIDTH  (A−B) mod 2^WIDTH (two's-complement wrap).
- o_value_mul  output  WIDTH  (A×B) mod 2^WIDTH (low WIDTH bits of product).
- o_value_div  output  WIDTH  floor(A/B); all-ones when B=0.
- o_value_rem  output  WIDTH  A mod B; equals A when B=0.
- o_div_by_zero  output  1  B was zero for the published result.

## Operation
- States: IDLE, DIV, DONE.
- IDLE:
  - o_busy=0.
  - On i_start=1: latch A and B into internal registers, clear partial remainder, load quotient shift register with A, clear iteration counter, go to DIV.
- DIV:
  - o_busy=1.
  - One restoring step per cycle: shift {rem,quot} left by 1, trial-subtract B from rem.
  - If non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0.
  - After WIDTH steps go to DONE.
- DONE (one cycle):
  - o_busy=0, o_valid=1.
  - All five results and o_div_by_zero are registered from the latched operands and divider state on the edge entering DONE.
  - Next edge returns to IDLE, or to DIV if i_start=1 (back-to-back accepted).
- Add, sub and mul are computed from the latched operands, not the live inputs. Input changes after the start edge have no effect.
- B=0 needs no special path: the restoring algorithm yields quotient all-ones and remainder A. o_div_by_zero = (latched B == 0).
- Result outputs hold their last published values until the next DONE. o_valid is low in all other states.
- i_start while o_busy=1 is ignored, not queued.

## Timing
- Reset (async assert, sync deassert by design owner): state=IDLE, all outputs 0, internal registers 0.
- Start sampled at edge 0. Iterations occur on edges 1..WIDTH. Results and o_valid=1 are registered on edge WIDTH+1.
- Latency from start edge to valid is WIDTH+1 cycles: 9 for WIDTH=8.
- o_busy is high from after edge 0 until edge WIDTH+1.
- Throughput: a new start is accepted in the o_valid cycle, giving one result set per WIDTH+1 cycles.
- Reset asserted mid-operation aborts immediately. No o_valid is produced, and outputs clear to 0.

## Test plan
- A=20, B=10, start → after 9 cycles o_valid=1 for 1 cycle; add=30, sub=10, mul=200, div=2, rem=0, div_by_zero=0.
- A=10, B=20 → sub=246 (0xF6), div=0, rem=10. A=200, B=100 → add=44 (wrap).
- A=20, B=20 → mul=144 (0x90, low byte of 400), div=1, rem=0. A=255, B=7 → div=36, rem=3.
- A=37, B=0 → div=255, rem=37, div_by_zero=1, latency still 9.
- Start A=20, B=10, then start again with A=1, B=1 and change the inputs while busy → second start ignored, first results unaffected. A start in the o_valid cycle is accepted, and its results follow 9 cycles later.
- rst_n low at cycle 4 of an operation → all outputs 0 immediately, o_valid never pulses. The next start after release completes normally.
